// File: rtl/permuter_network_if.sv
// Lane bundle for the deflection permutation network: per-lane flit inputs,
// per-lane permuted outputs and the deflection counter.
interface permuter_network_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 64,
  parameter int PRIO_W  = 8,
  parameter int CNT_W   = 16
);
  localparam int L = $clog2(N_PORTS);

  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS*PRIO_W-1:0] in_prio;
  logic [N_PORTS*L-1:0]      in_dst;
  logic [N_PORTS*DATA_W-1:0] in_data;

  logic [N_PORTS-1:0]        out_valid;
  logic [N_PORTS*DATA_W-1:0] out_data;
  logic [N_PORTS-1:0]        out_defl;
  logic [N_PORTS*L-1:0]      out_dst;
  logic [CNT_W-1:0]          defl_cnt;

  modport master (
    output in_valid, in_prio, in_dst, in_data,
    input  out_valid, out_data, out_defl, out_dst, defl_cnt
  );

  modport slave (
    input  in_valid, in_prio, in_dst, in_data,
    output out_valid, out_data, out_defl, out_dst, defl_cnt
  );
endinterface

// File: rtl/permuter_network.sv
// log2(N)-stage butterfly of self-arbitrating 2x2 swap cells for the MinBD
// deflection datapath, with optional per-stage registers and a deflection counter.
module permuter_network #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 64,
  parameter int PRIO_W  = 8,
  parameter int REG_MID = 0,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cnt_clr,
  permuter_network_if.slave bus
);
  localparam int L  = $clog2(N_PORTS);
  localparam int IW = $clog2(N_PORTS + 1);
  localparam int SW = ((CNT_W > IW) ? CNT_W : IW) + 1;

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int B = L - 1 - s;

    logic [N_PORTS-1:0]        a_v, a_f, c_v, c_f, q_v, q_f;
    logic [N_PORTS*PRIO_W-1:0] a_p, c_p, q_p;
    logic [N_PORTS*L-1:0]      a_x, c_x, q_x;
    logic [N_PORTS*DATA_W-1:0] a_d, c_d, q_d;

    if (s == 0) begin : g_in
      assign a_v = bus.in_valid;
      assign a_f = '0;
      assign a_p = bus.in_prio;
      assign a_x = bus.in_dst;
      assign a_d = bus.in_data;
    end else begin : g_link
      assign a_v = g_stage[s-1].q_v;
      assign a_f = g_stage[s-1].q_f;
      assign a_p = g_stage[s-1].q_p;
      assign a_x = g_stage[s-1].q_x;
      assign a_d = g_stage[s-1].q_d;
    end

    for (genvar k = 0; k < N_PORTS / 2; k++) begin : g_cell
      localparam int I = ((k >> B) << (B + 1)) | (k & ((1 << B) - 1));
      localparam int J = I + (1 << B);

      logic vi, vj, win_j, wbit, swap, lose;

      assign vi    = a_v[I];
      assign vj    = a_v[J];
      assign win_j = vj & (~vi | (a_p[J*PRIO_W +: PRIO_W] > a_p[I*PRIO_W +: PRIO_W]));
      assign wbit  = win_j ? a_x[J*L + B] : a_x[I*L + B];
      // winner on lane j sits on a lane whose bit b is 1
      assign swap  = (vi | vj) & (wbit != win_j);
      // loser takes the lane the winner left, so it is deflected iff both want the same half
      assign lose  = vi & vj & (a_x[I*L + B] == a_x[J*L + B]);

      assign c_v[I] = swap ? vj : vi;
      assign c_v[J] = swap ? vi : vj;
      assign c_f[I] = (swap ? a_f[J] : a_f[I]) | (lose & wbit);
      assign c_f[J] = (swap ? a_f[I] : a_f[J]) | (lose & ~wbit);
      assign c_p[I*PRIO_W +: PRIO_W] = swap ? a_p[J*PRIO_W +: PRIO_W] : a_p[I*PRIO_W +: PRIO_W];
      assign c_p[J*PRIO_W +: PRIO_W] = swap ? a_p[I*PRIO_W +: PRIO_W] : a_p[J*PRIO_W +: PRIO_W];
      assign c_x[I*L +: L] = swap ? a_x[J*L +: L] : a_x[I*L +: L];
      assign c_x[J*L +: L] = swap ? a_x[I*L +: L] : a_x[J*L +: L];
      assign c_d[I*DATA_W +: DATA_W] = swap ? a_d[J*DATA_W +: DATA_W] : a_d[I*DATA_W +: DATA_W];
      assign c_d[J*DATA_W +: DATA_W] = swap ? a_d[I*DATA_W +: DATA_W] : a_d[J*DATA_W +: DATA_W];
    end

    // last stage is always registered: it doubles as the output register
    if (REG_MID != 0 || s == L - 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          {q_v, q_f, q_p, q_x, q_d} <= '0;
        end else if (en) begin
          q_v <= c_v;
          q_f <= c_f;
          q_p <= c_p;
          q_x <= c_x;
          q_d <= c_d;
        end
      end
    end else begin : g_comb
      assign q_v = c_v;
      assign q_f = c_f;
      assign q_p = c_p;
      assign q_x = c_x;
      assign q_d = c_d;
    end
  end

  assign bus.out_valid = g_stage[L-1].q_v;
  assign bus.out_defl  = g_stage[L-1].q_f;
  assign bus.out_dst   = g_stage[L-1].q_x;
  assign bus.out_data  = g_stage[L-1].q_d;

  logic unused_prio;
  assign unused_prio = ^g_stage[L-1].q_p;

  logic [N_PORTS-1:0] ld_defl;
  logic [IW-1:0]      inc;
  logic [SW-1:0]      sum;
  logic [CNT_W-1:0]   cnt_q;

  assign ld_defl = g_stage[L-1].c_v & g_stage[L-1].c_f;

  always_comb begin
    inc = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      inc = inc + IW'(ld_defl[i]);
    end
  end

  assign sum = SW'(cnt_q) + SW'(inc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (|sum[SW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end
  end

  assign bus.defl_cnt = cnt_q;
endmodule
